// File: rtl/pac_poly_pkg.sv
// pac_poly_pkg
// Shared constants and types for the polyphonic phase accumulator and the
// sine approximator that consumes its phases.
//   DEF_NUM_VOICES : default number of time-multiplexed voices
//   DEF_PHASE_W    : default phase accumulator width
//   DEF_INC_W      : default increment width (zero-extended into the phase)
//   DEF_DIV_W      : default tick divider width
//   phase_t, inc_t : phase / increment words at the default widths
//   state_t        : sweep controller states
package pac_poly_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_PHASE_W    = 16;
    localparam int DEF_INC_W      = 16;
    localparam int DEF_DIV_W      = 12;

    typedef logic [DEF_PHASE_W-1:0] phase_t;
    typedef logic [DEF_INC_W-1:0]   inc_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

endpackage

// File: rtl/pac_tick_div.sv
// pac_tick_div
// Programmable tick divider: counts 0..div_max-1 and emits a registered
// one-cycle tick the cycle after the count reaches div_max-1.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   div_max : tick period in clk cycles, 0 halts ticking
//   tick    : one-cycle tick pulse
module pac_tick_div
    import pac_poly_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_max,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last_count;

    assign last_count = div_max - DIV_W'(1);

    // A count beyond the terminal value (div_max lowered mid-count) wraps
    // to zero silently; only an exact terminal match produces a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (div_max == '0) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= last_count) begin
            count <= '0;
            tick  <= (count == last_count);
        end else begin
            count <= count + DIV_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/pac_poly.sv
// pac_poly
// Polyphonic phase accumulator: NUM_VOICES phases share one adder. Each
// divider tick starts a sweep that updates voice 0..NUM_VOICES-1 on
// consecutive cycles and streams the new phases out, one cycle later.
// Optional build macro PAC_POLY_SYNC_EN adds per-voice hard sync.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   div_max     : tick period in clk cycles, 0 halts ticking
//   inc_we      : increment write strobe for inc[inc_voice] <= inc_data
//   sync        : per-voice hard-sync requests (PAC_POLY_SYNC_EN only)
//   phase_valid : phase_out / phase_voice carry a fresh update
//   phase_voice : voice index of phase_out
//   phase_out   : updated phase value
//   phase_wrap  : adder carry-out for this update
//   overrun     : sticky, a tick arrived while a sweep was in progress
module pac_poly
    import pac_poly_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int INC_W      = DEF_INC_W,
    parameter int DIV_W      = DEF_DIV_W,
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   div_max,
    input  logic               inc_we,
    input  logic [VOICE_W-1:0] inc_voice,
    input  logic [INC_W-1:0]   inc_data,
`ifdef PAC_POLY_SYNC_EN
    input  logic [NUM_VOICES-1:0] sync,
`endif
    output logic               phase_valid,
    output logic [VOICE_W-1:0] phase_voice,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_wrap,
    output logic               overrun
);

    localparam logic [VOICE_W-1:0] LAST_IDX  = VOICE_W'(NUM_VOICES - 1);
    localparam logic [VOICE_W:0]   VOICE_CNT = (VOICE_W + 1)'(NUM_VOICES);

    state_t               state;
    state_t               state_next;
    logic [VOICE_W-1:0]   idx;
    logic [VOICE_W-1:0]   idx_next;
    logic                 slot_active;
    logic                 tick;
    logic                 load_zero;
    logic [PHASE_W:0]     sum;
    logic [PHASE_W-1:0]   slot_phase;
    logic                 slot_wrap;

    logic [PHASE_W-1:0]   phase [NUM_VOICES];
    logic [INC_W-1:0]     inc   [NUM_VOICES];

    pac_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_max (div_max),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        slot_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_SWEEP;
                    idx_next   = '0;
                end
            end
            ST_SWEEP: begin
                slot_active = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + VOICE_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Shared adder; the extra top bit is the wrap (carry-out) flag.
    always_comb begin
        sum        = {1'b0, phase[idx]} + {{(PHASE_W + 1 - INC_W){1'b0}}, inc[idx]};
        slot_phase = load_zero ? '0 : sum[PHASE_W-1:0];
        slot_wrap  = load_zero ? 1'b0 : sum[PHASE_W];
    end

`ifdef PAC_POLY_SYNC_EN
    logic [NUM_VOICES-1:0] pending;
    logic [NUM_VOICES-1:0] slot_mask;

    // A request arriving during its own slot is honoured immediately.
    assign slot_mask = slot_active ? (NUM_VOICES'(1) << idx) : '0;
    assign load_zero = slot_active && (pending[idx] || sync[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | sync) & ~slot_mask;
        end
    end
`else
    assign load_zero = 1'b0;
`endif

    // Increment writes land at the same edge that registers the current
    // slot, so a write to the voice being processed affects the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
            end
            phase_valid <= 1'b0;
            phase_voice <= '0;
            phase_out   <= '0;
            phase_wrap  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (inc_we && ({1'b0, inc_voice} < VOICE_CNT)) begin
                inc[inc_voice] <= inc_data;
            end
            if (slot_active) begin
                phase[idx]  <= slot_phase;
                phase_valid <= 1'b1;
                phase_voice <= idx;
                phase_out   <= slot_phase;
                phase_wrap  <= slot_wrap;
            end else begin
                phase_valid <= 1'b0;
                phase_wrap  <= 1'b0;
            end
            if (tick && (state == ST_SWEEP)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pac_poly.sv
// tb_pac_poly
// Directed sequence with randomized increments and divider periods for
// pac_poly at default parameters. The reference keeps one integer phase
// and increment per voice and predicts each burst with modular arithmetic;
// burst spacing follows from the divider period and the sweep length.
module tb_pac_poly;

    localparam int NV = 4;
    localparam int PW = 16;
    localparam int IW = 16;
    localparam int DW = 12;
    localparam int PHASE_MOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] div_max = '0;
    logic          inc_we = 1'b0;
    logic [1:0]    inc_voice = '0;
    logic [IW-1:0] inc_data = '0;
`ifdef PAC_POLY_SYNC_EN
    logic [NV-1:0] sync = '0;
    bit            m_pend [NV];
`endif
    logic          phase_valid;
    logic [1:0]    phase_voice;
    logic [PW-1:0] phase_out;
    logic          phase_wrap;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_phase [NV];
    int m_inc [NV];

    pac_poly dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_max     (div_max),
        .inc_we      (inc_we),
        .inc_voice   (inc_voice),
        .inc_data    (inc_data),
`ifdef PAC_POLY_SYNC_EN
        .sync        (sync),
`endif
        .phase_valid (phase_valid),
        .phase_voice (phase_voice),
        .phase_out   (phase_out),
        .phase_wrap  (phase_wrap),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int voice, input int data);
        inc_we    = 1'b1;
        inc_voice = 2'(voice);
        inc_data  = IW'(data);
        @(negedge clk);
        inc_we    = 1'b0;
        m_inc[voice] = data;
    endtask

    task automatic clearModel();
        for (int k = 0; k < NV; k++) begin
            m_phase[k] = 0;
            m_inc[k]   = 0;
`ifdef PAC_POLY_SYNC_EN
            m_pend[k]  = 1'b0;
`endif
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(phase_valid), 32'd0);
        checkOutput({tag, "_voice"}, 32'(phase_voice), 32'd0);
        checkOutput({tag, "_out"}, 32'(phase_out), 32'd0);
        checkOutput({tag, "_wrap"}, 32'(phase_wrap), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n   = 1'b0;
        div_max = '0;
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic randomIncs(input int force2);
        for (int k = 0; k < NV; k++) begin
            if (k == 2 && force2 >= 0) applyStimulus(k, force2);
            else applyStimulus(k, int'($urandom_range(0, PHASE_MOD - 1)));
        end
    endtask

    task automatic waitBurst(input string tag, output int start);
        int n = 0;
        while (phase_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_seen"}, 32'(phase_valid), 32'd1);
        start = cyc;
    endtask

    task automatic checkBurst(input string tag, input bit write_mid, input int wdata);
        int s;
        int exp_out;
        int exp_wrap;
        for (int k = 0; k < NV; k++) begin
            s        = m_phase[k] + m_inc[k];
            exp_out  = s % PHASE_MOD;
            exp_wrap = (s >= PHASE_MOD) ? 1 : 0;
`ifdef PAC_POLY_SYNC_EN
            if (m_pend[k]) begin
                exp_out   = 0;
                exp_wrap  = 0;
                m_pend[k] = 1'b0;
            end
`endif
            checkOutput($sformatf("%s_v%0d_valid", tag, k), 32'(phase_valid), 32'd1);
            checkOutput($sformatf("%s_v%0d_voice", tag, k), 32'(phase_voice), 32'(k));
            checkOutput($sformatf("%s_v%0d_out", tag, k), 32'(phase_out), 32'(exp_out));
            checkOutput($sformatf("%s_v%0d_wrap", tag, k), 32'(phase_wrap), 32'(exp_wrap));
            m_phase[k] = exp_out;
            if (write_mid && k == 0) begin
                inc_we    = 1'b1;
                inc_voice = 2'd1;
                inc_data  = IW'(wdata);
            end
            @(negedge clk);
            inc_we = 1'b0;
        end
        if (write_mid) m_inc[1] = wdata;
        checkOutput({tag, "_end_valid"}, 32'(phase_valid), 32'd0);
        checkOutput({tag, "_end_wrap"}, 32'(phase_wrap), 32'd0);
        checkOutput({tag, "_hold_out"}, 32'(phase_out), 32'(m_phase[NV-1]));
        checkOutput({tag, "_hold_voice"}, 32'(phase_voice), 32'(NV - 1));
    endtask

    initial begin
        int t0;
        int st;
        int prev;
        int dm;
        bit seen;

        clearModel();

        // Reset state
        #12;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed increments 1..4, period 8
        for (int k = 0; k < NV; k++) applyStimulus(k, k + 1);
        div_max = DW'(8);
        t0 = cyc;
        waitBurst("p8_first", st);
        checkOutput("p8_latency", 32'(st - t0), 32'd10);
        checkBurst("p8_b0", 1'b0, 0);
        for (int b = 1; b < 3; b++) begin
            prev = st;
            waitBurst($sformatf("p8_b%0d", b), st);
            checkOutput($sformatf("p8_b%0d_spacing", b), 32'(st - prev), 32'd8);
            checkBurst($sformatf("p8_b%0d", b), 1'b0, 0);
        end
        checkOutput("p8_overrun", 32'(overrun), 32'd0);

`ifdef PAC_POLY_SYNC_EN
        // Hard sync on voice 3 between sweeps
        sync = 4'b1000;
        m_pend[3] = 1'b1;
        @(negedge clk);
        sync = '0;
        waitBurst("sync", st);
        checkBurst("sync", 1'b0, 0);
`endif

        // Random increments, voice 2 steps a quarter turn, random period
        resetDut();
        randomIncs(32'h4000);
        dm = int'($urandom_range(5, 12));
        div_max = DW'(dm);
        t0 = cyc;
        waitBurst("rnd_first", st);
        checkOutput("rnd_latency", 32'(st - t0), 32'(dm + 2));
        checkBurst("rnd_b0", 1'b0, 0);
        for (int b = 1; b < 5; b++) begin
            prev = st;
            waitBurst($sformatf("rnd_b%0d", b), st);
            checkOutput($sformatf("rnd_b%0d_spacing", b), 32'(st - prev), 32'(dm));
            checkBurst($sformatf("rnd_b%0d", b), (b == 2), 32'h0100);
        end
        checkOutput("rnd_overrun", 32'(overrun), 32'd0);

        // Fast periods: accepted ticks are spaced by the first period
        // multiple that exceeds the sweep length
        for (int p = 1; p <= 2; p++) begin
            resetDut();
            randomIncs(-1);
            div_max = DW'(p);
            t0 = cyc;
            waitBurst($sformatf("fast%0d_first", p), st);
            checkOutput($sformatf("fast%0d_latency", p), 32'(st - t0), 32'(p + 2));
            checkBurst($sformatf("fast%0d_b0", p), 1'b0, 0);
            for (int b = 1; b < 3; b++) begin
                prev = st;
                waitBurst($sformatf("fast%0d_b%0d", p, b), st);
                checkOutput($sformatf("fast%0d_b%0d_spacing", p, b), 32'(st - prev),
                            32'(p * ((NV + p) / p)));
                checkBurst($sformatf("fast%0d_b%0d", p, b), 1'b0, 0);
            end
            checkOutput($sformatf("fast%0d_overrun", p), 32'(overrun), 32'd1);
        end

        // Reset asserted during slot 2 of a sweep
        resetDut();
        randomIncs(-1);
        div_max = DW'(6);
        waitBurst("rst_mid", st);
        checkOutput("rst_mid_v0_out", 32'(phase_out), 32'(m_inc[0]));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rst_mid_now");
        clearModel();
        div_max = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Halted divider never starts a sweep
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (phase_valid !== 1'b0) seen = 1'b1;
        end
        checkOutput("halt_no_valid", 32'(seen), 32'd0);

        div_max = DW'(6);
        waitBurst("post_rst", st);
        checkBurst("post_rst", 1'b0, 0);
        checkOutput("post_rst_overrun", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pac_poly.md
PAC_POLY -- requirements
Module: pac_poly

Interface
REQ-001 Parameter NUM_VOICES, default 4: voices sharing one adder, time-multiplexed.
REQ-002 Parameter PHASE_W, default 16: phase accumulator width per voice.
REQ-003 Parameter INC_W, default 16: increment width, INC_W <= PHASE_W, zero-extended.
REQ-004 Parameter DIV_W, default 12: tick divider width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 div_max  in  DIV_W  tick period in clk cycles; 0 halts ticking.
REQ-008 inc_we  in  1  increment write strobe.
REQ-009 inc_voice  in  clog2(NUM_VOICES)  voice addressed by inc_we.
REQ-010 inc_data  in  INC_W  increment value written.
REQ-011 sync  in  NUM_VOICES  per-voice hard-sync request (present only with PAC_POLY_SYNC_EN).
REQ-012 phase_valid  out  1  phase_out/phase_voice valid this cycle.
REQ-013 phase_voice  out  clog2(NUM_VOICES)  voice index of phase_out.
REQ-014 phase_out  out  PHASE_W  updated phase of phase_voice.
REQ-015 phase_wrap  out  1  phase_out update wrapped past 2^PHASE_W.
REQ-016 overrun  out  1  sticky: tick arrived while sweep busy.

Function
REQ-017 Divider counter SHALL count 0..div_max-1 and wrap; tick SHALL be a registered one-cycle pulse asserted the cycle after counter == div_max-1.
REQ-018 div_max change mid-count: if counter >= new div_max-1, counter SHALL wrap to 0 next cycle without tick.
REQ-019 FSM states IDLE, SWEEP; IDLE->SWEEP on tick with index 0; SWEEP advances index each cycle; SWEEP->IDLE after index NUM_VOICES-1.
REQ-020 In SWEEP slot k, phase[k] SHALL become (phase[k] + inc[k]) mod 2^PHASE_W; no saturation, no clamp.
REQ-021 Outputs SHALL be registered: phase_valid high for exactly NUM_VOICES consecutive cycles, voice k valid one cycle after slot k, phase_voice ascending 0..NUM_VOICES-1.
REQ-022 phase_wrap SHALL equal the adder carry-out for that slot; it is 0 when phase_valid is low.
REQ-023 phase_out/phase_voice SHALL hold last values when phase_valid is low.
REQ-024 Tick arriving in SWEEP SHALL be dropped and set overrun; overrun clears only on reset.
REQ-025 inc_we SHALL update inc[inc_voice] at the clock edge; write in the same cycle as that voice's slot: slot uses old value.
REQ-026 inc_voice >= NUM_VOICES SHALL be ignored.
REQ-027 div_max == 1 SHALL tick every cycle (overrun expected when NUM_VOICES > 1).

Reset
REQ-028 rst_n low SHALL immediately clear counter, tick, FSM (IDLE), all phases, all increments, phase_valid, phase_voice, phase_out, phase_wrap, overrun to 0.
REQ-029 Reset mid-sweep SHALL abort sweep; first tick after release starts at voice 0.

Configuration
REQ-030 Macro PAC_POLY_SYNC_EN defined: sync[k] is latched as pending; at slot k a pending sync SHALL load phase[k] = 0 (increment not added), phase_wrap = 0, pending cleared; sync[k] asserted in the same cycle as slot k SHALL take effect in that slot.
REQ-031 PAC_POLY_SYNC_EN undefined: sync port and pending logic absent; behaviour per REQ-020 only.

Structure
REQ-032 Shared constants package SHALL hold default widths (PHASE_W, INC_W, DIV_W, NUM_VOICES) and the phase/increment typedefs used by the downstream sine approximator.
REQ-033 Divider (counter + tick, REQ-017/018) SHALL be sub-module pac_tick_div; accumulator RAM, FSM and adder stay in pac_poly.

Verification
REQ-034 div_max=8, inc[0..3]=1,2,3,4 -> every 8 cycles, 4-cycle valid burst; after 3 ticks phases 3,6,9,12, no overrun.
REQ-035 PHASE_W=16, inc[2]=0x4000, 4 ticks -> voice 2 phase 0x4000,0x8000,0xC000,0x0000 with phase_wrap=1 on the fourth only.
REQ-036 div_max=2, NUM_VOICES=4 -> overrun set after second tick, every other tick dropped, phases advance once per completed sweep.
REQ-037 inc_we to voice 1 with 0x0100 in the same cycle as slot 1 -> that slot uses old increment, next sweep adds 0x0100.
REQ-038 PAC_POLY_SYNC_EN, phase[3]=0x1234, sync[3] pulse between sweeps -> next voice-3 output 0x0000, wrap 0; others unaffected.
REQ-039 rst_n low during slot 2 -> all outputs 0 immediately; after release, next burst starts voice 0 from phase inc[0] = 0 (increments cleared).
